// File: rtl/nios_sys_debug_pkg.sv
// Shared constants and helpers for the sysclk-side CPU debug slave.
// IR code values, default widths and strobe-lane helpers.
package nios_sys_debug_pkg;

  localparam int IR_OCIMEM    = 0;
  localparam int IR_TRACEMEM  = 1;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;

  localparam int DEF_SR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  function automatic int lane_count(int ir_width);
    return 1 << ir_width;
  endfunction

  function automatic logic lane_hit(int ir_code, int lane);
    return (ir_code == lane);
  endfunction

endpackage

// File: rtl/nios_sys_debug_sync_edge.sv
// Level synchroniser followed by a registered rising-edge detector.
// A level held high yields a single one-cycle pulse.
module nios_sys_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], level};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
      pulse   <= sync_p0[SYNC_STAGES-1] & ~hist_p1;
    end
  end

endmodule

// File: rtl/nios_sys_nios2_debug_cmd_sysclk.sv
// Sysclk-side capture of TCK-domain debug commands: synchronised update pulses,
// a command FIFO with valid/ready output, and one-hot action strobes on pop.
module nios_sys_nios2_debug_cmd_sysclk
  import nios_sys_debug_pkg::*;
#(
  parameter int SR_WIDTH    = DEF_SR_WIDTH,
  parameter int IR_WIDTH    = DEF_IR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = 37
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [IR_WIDTH-1:0]               ir_in,
  input  logic [SR_WIDTH-1:0]               sr,
  input  logic                              vs_uir,
  input  logic                              vs_udr,
  input  logic                              cmd_ready,
  input  logic                              overflow_clr,
  output logic                              cmd_valid,
  output logic [IR_WIDTH-1:0]               cmd_ir,
  output logic [SR_WIDTH-1:0]               cmd_sr,
  output logic [SR_WIDTH-1:0]               jdo,
  output logic [(1<<IR_WIDTH)-1:0]          take_action,
  output logic [(1<<IR_WIDTH)-1:0]          take_no_action,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);

  localparam int NCODES = lane_count(IR_WIDTH);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = $clog2(FIFO_DEPTH+1);
  localparam int EW     = IR_WIDTH + SR_WIDTH;

  logic uir_p;
  logic udr_p;

  nios_sys_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_uir),
    .pulse   (uir_p)
  );

  nios_sys_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_udr),
    .pulse   (udr_p)
  );

  logic [IR_WIDTH-1:0] ir_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg <= '0;
    end else if (uir_p) begin
      ir_reg <= ir_in;
    end
  end

  // ---- command queue ----
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic [EW-1:0]       head;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_valid = (fifo_level != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
  assign push_ok   = udr_p & (~full | pop);
  assign drop      = udr_p & full & ~pop;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_ir    = cmd_valid ? head[EW-1:SR_WIDTH] : '0;
  assign cmd_sr    = cmd_valid ? head[SR_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {ir_reg, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // ---- pop / strobe stage ----
  logic [NCODES-1:0] lane_vec_p0;

  always_comb begin
    lane_vec_p0 = '0;
    for (int i = 0; i < NCODES; i++) begin
      lane_vec_p0[i] = lane_hit(int'(cmd_ir), i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (pop &&  cmd_sr[ACTION_BIT]) ? lane_vec_p0 : '0;
      take_no_action <= (pop && !cmd_sr[ACTION_BIT]) ? lane_vec_p0 : '0;
      if (pop) jdo <= cmd_sr;
    end
  end

endmodule

// File: tb/tb_nios_sys_nios2_debug_cmd_sysclk.sv
// Directed bench for the sysclk debug command capture/queue block.
module tb_nios_sys_nios2_debug_cmd_sysclk;
  import nios_sys_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic        cmd_ready;
  logic        overflow_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_sr;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  fifo_level;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  nios_sys_nios2_debug_cmd_sysclk dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_ready      (cmd_ready),
    .overflow_clr   (overflow_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_sr         (cmd_sr),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic uir_pulse(input logic [1:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
  endtask

  // Push lands on the 4th edge after vs_udr rises (SYNC_STAGES=2).
  task automatic udr_pulse(input logic [37:0] val);
    sr     = val;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic pop_one(input logic [37:0] exp_sr, input string tag);
    checks++;
    if (cmd_sr !== exp_sr) begin
      errors++;
      $display("FAIL %s head: cmd_sr=%h expected %h", tag, cmd_sr, exp_sr);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if (jdo !== exp_sr) begin
      errors++;
      $display("FAIL %s jdo: jdo=%h expected %h", tag, jdo, exp_sr);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({cmd_valid, fifo_level, take_action, take_no_action, overflow, jdo, cmd_sr} !== '0) begin
      errors++;
      $display("FAIL %s: valid=%b level=%0d ta=%b tna=%b ovf=%b jdo=%h cmd_sr=%h expected all zero",
               tag, cmd_valid, fifo_level, take_action, take_no_action, overflow, jdo, cmd_sr);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 0; vs_udr = 0;
    cmd_ready = 0; overflow_clr = 0;
    tick(3);
    check_idle("reset");
    reset_n = 1'b1;
    tick(2);
    check_idle("post_reset");
  endtask

  task automatic test_action(input string tag);
    uir_pulse(2'(IR_BREAK));
    sr     = 38'h20_0000_00AB;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: cmd_valid=%b expected 0", tag, cmd_valid);
    end
    tick();
    checks++;
    if ({cmd_valid, cmd_ir, cmd_sr} !== {1'b1, 2'd2, 38'h20_0000_00AB}) begin
      errors++;
      $display("FAIL %s latency: valid=%b ir=%0d sr=%h expected 1 2 2000000ab", tag, cmd_valid, cmd_ir, cmd_sr);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if ({take_action, take_no_action, jdo, fifo_level} !== {4'b0100, 4'b0000, 38'h20_0000_00AB, 3'd0}) begin
      errors++;
      $display("FAIL %s strobe: ta=%b tna=%b jdo=%h level=%0d expected 0100 0000 2000000ab 0",
               tag, take_action, take_no_action, jdo, fifo_level);
    end
    tick();
    checks++;
    if ({take_action, take_no_action} !== 8'h00) begin
      errors++;
      $display("FAIL %s strobe_clear: ta=%b tna=%b expected 0", tag, take_action, take_no_action);
    end
  endtask

  task automatic test_no_action;
    uir_pulse(2'(IR_OCIMEM));
    udr_pulse(38'h00_0000_0055);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if ({take_action, take_no_action, jdo} !== {4'b0000, 4'b0001, 38'h00_0000_0055}) begin
      errors++;
      $display("FAIL no_action strobe: ta=%b tna=%b jdo=%h expected 0000 0001 55", take_action, take_no_action, jdo);
    end
    tick();
    checks++;
    if ({take_action, take_no_action} !== 8'h00) begin
      errors++;
      $display("FAIL no_action one_cycle: ta=%b tna=%b expected 0", take_action, take_no_action);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) udr_pulse(38'(i));
    checks++;
    if ({fifo_level, overflow} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL overflow fill: level=%0d ovf=%b expected 4 1", fifo_level, overflow);
    end
    for (int i = 1; i <= 4; i++) pop_one(38'(i), "overflow_order");
    checks++;
    if ({cmd_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL overflow drained: valid=%b level=%0d ovf=%b expected 0 0 1", cmd_valid, fifo_level, overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow clear: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop;
    for (int i = 1; i <= 4; i++) udr_pulse(38'(16 + i));
    sr     = 38'd9;
    vs_udr = 1'b1;
    tick(3);
    vs_udr    = 1'b0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if ({fifo_level, overflow, jdo} !== {3'd4, 1'b0, 38'd17}) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d ovf=%b jdo=%0d expected 4 0 17", fifo_level, overflow, jdo);
    end
    tick(2);
    for (int i = 2; i <= 4; i++) pop_one(38'(16 + i), "full_order");
    pop_one(38'd9, "full_last");
    for (int k = 0; k < 10; k++) begin
      udr_pulse(38'(100 + k));
      pop_one(38'(100 + k), "wrap");
    end
    checks++;
    if ({cmd_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL wrap end: valid=%b level=%0d ovf=%b expected 0 0 0", cmd_valid, fifo_level, overflow);
    end
  endtask

  task automatic test_levels;
    sr     = 38'h3A;
    vs_udr = 1'b1;
    tick(20);
    vs_udr = 1'b0;
    tick(3);
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL held_udr: level=%0d expected 1", fifo_level);
    end
    pop_one(38'h3A, "held_udr");
    uir_pulse(2'(IR_TRACEMEM));
    ir_in  = 2'(IR_TRACECTRL);
    sr     = 38'h77;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(3);
    checks++;
    if ({fifo_level, cmd_ir} !== {3'd1, 2'd1}) begin
      errors++;
      $display("FAIL same_cycle_ir: level=%0d cmd_ir=%0d expected 1 1", fifo_level, cmd_ir);
    end
    pop_one(38'h77, "same_cycle");
    udr_pulse(38'h78);
    checks++;
    if (cmd_ir !== 2'd3) begin
      errors++;
      $display("FAIL ir_reg_after: cmd_ir=%0d expected 3", cmd_ir);
    end
    pop_one(38'h78, "ir_after");
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 5; i++) udr_pulse(38'h20_0000_0000 | 38'(i));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if ({fifo_level, overflow, take_action} !== {3'd3, 1'b1, 4'b1000}) begin
      errors++;
      $display("FAIL pre_reset: level=%0d ovf=%b ta=%b expected 3 1 1000", fifo_level, overflow, take_action);
    end
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_action("action");
    test_no_action();
    test_overflow();
    test_full_push_pop();
    test_levels();
    test_reset_mid();
    test_action("action_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
